// File: rtl/tmr0_wdt_ctrl.sv
// tmr0_wdt_ctrl
// Timer0 / watchdog timing controller for a PIC16F54-class core. It turns the
// OPTION register bits, the T0CKI pin and core events (TMR0 write, CLRWDT,
// SLEEP) into single-cycle increment/timeout strobes. It keeps the STATUS TO/PD
// flags and owns the 8-bit prescaler that is shared between Timer0 and the WDT.
//
// Ports
//   clk      in   core clock, one clock per instruction cycle
//   rst      in   asynchronous active-low reset
//   option   in   OPTION register: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS
//   t0cki    in   external Timer0 clock pin (asynchronous)
//   tmr0_wr  in   core writes TMR0 this cycle
//   clrwdt   in   CLRWDT executes this cycle
//   sleep    in   SLEEP executes this cycle
//   wdt_en   in   WDT enable fuse (static)
//   tmr0_inc out  one-cycle TMR0 increment pulse (registered)
//   wdtmr    out  one-cycle WDT timeout pulse (registered)
//   to_n     out  STATUS TO bit
//   pd_n     out  STATUS PD bit
module tmr0_wdt_ctrl #(
    parameter int WDT_BASE_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] option,
    input  logic       t0cki,
    input  logic       tmr0_wr,
    input  logic       clrwdt,
    input  logic       sleep,
    input  logic       wdt_en,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic       to_n,
    output logic       pd_n
);

    // Registered state
    logic [3:0]            opt_r;
    logic [1:0]            arm_r;
    logic                  sync1_r;
    logic                  sync2_r;
    logic                  edge_r;
    logic [1:0]            inh_r;
    logic                  asleep_r;
    logic [7:0]            psc_r;
    logic [WDT_BASE_W-1:0] base_r;
    logic                  tmr0_inc_r;
    logic                  wdtmr_r;
    logic                  to_n_r;
    logic                  pd_n_r;

    // Combinational next-state and decode
    logic                  psa_s;
    logic                  armed_s;
    logic                  opt_chg_s;
    logic                  rise_s;
    logic                  fall_s;
    logic                  src_evt_s;
    logic                  t0_evt_s;
    logic                  wdt_clr_s;
    logic                  base_tick_s;
    logic [3:0]            psc_shift_s;
    logic [8:0]            psc_mask9_s;
    logic [7:0]            psc_last_s;
    logic                  ratio_one_s;
    logic                  psc_evt_s;
    logic                  owner_clr_s;
    logic                  psc_fire_s;
    logic [7:0]            psc_nxt_s;
    logic                  t0_fire_s;
    logic                  wdt_fire_s;
    logic [WDT_BASE_W-1:0] base_nxt_s;
    logic [1:0]            inh_nxt_s;
    logic [1:0]            arm_nxt_s;
    logic                  to_n_nxt_s;
    logic                  pd_n_nxt_s;
    logic                  unused_s;

    assign unused_s = ^{option[7:6], psc_mask9_s[8]};

    // Source qualification, prescaler arbitration and WDT base decode
    always_comb begin
        psa_s   = option[3];
        armed_s = (arm_r == 2'd3);
        // The copy taken at the first edge after reset is initialisation, not
        // a reassignment, so change detection waits until the copy is valid.
        opt_chg_s = (arm_r != 2'd0) && (option[3:0] != opt_r);

        rise_s = sync2_r & ~edge_r;
        fall_s = ~sync2_r & edge_r;
        if (option[5]) begin
            src_evt_s = armed_s & (option[4] ? fall_s : rise_s);
        end else begin
            src_evt_s = 1'b1;
        end
        // A Timer0 event only counts if not overridden by a write, the
        // post-write inhibit window or sleep.
        t0_evt_s = src_evt_s & ~tmr0_wr & (inh_r == 2'd0) & ~asleep_r & ~sleep;

        wdt_clr_s   = clrwdt | sleep;
        base_tick_s = wdt_en & ~wdt_clr_s & (base_r == {WDT_BASE_W{1'b1}});

        // Ratio is a power of two: Timer0 uses 2^(PS+1), WDT uses 2^PS.
        if (psa_s) begin
            psc_shift_s = {1'b0, option[2:0]};
        end else begin
            psc_shift_s = {1'b0, option[2:0]} + 4'd1;
        end
        psc_mask9_s = (9'd1 << psc_shift_s) - 9'd1;
        psc_last_s  = psc_mask9_s[7:0];
        ratio_one_s = (psc_shift_s == 4'd0);

        psc_evt_s   = psa_s ? base_tick_s : t0_evt_s;
        owner_clr_s = psa_s ? wdt_clr_s : tmr0_wr;

        psc_fire_s = 1'b0;
        psc_nxt_s  = psc_r;
        if (opt_chg_s || owner_clr_s) begin
            psc_nxt_s = 8'd0;
        end else if (psc_evt_s) begin
            if (ratio_one_s || (psc_r == psc_last_s)) begin
                psc_fire_s = 1'b1;
                psc_nxt_s  = 8'd0;
            end else begin
                psc_nxt_s = psc_r + 8'd1;
            end
        end else begin
            psc_nxt_s = psc_r;
        end

        // The non-owner of the prescaler sees its event at ratio 1.
        t0_fire_s  = psa_s ? t0_evt_s : psc_fire_s;
        wdt_fire_s = psa_s ? psc_fire_s : base_tick_s;

        if (wdt_clr_s || !wdt_en) begin
            base_nxt_s = {WDT_BASE_W{1'b0}};
        end else begin
            base_nxt_s = base_r + WDT_BASE_W'(1);
        end

        if (tmr0_wr) begin
            inh_nxt_s = 2'd2;
        end else if (inh_r != 2'd0) begin
            inh_nxt_s = inh_r - 2'd1;
        end else begin
            inh_nxt_s = 2'd0;
        end

        if (arm_r == 2'd3) begin
            arm_nxt_s = 2'd3;
        end else begin
            arm_nxt_s = arm_r + 2'd1;
        end

        // A clear in the same cycle as a timeout wins, so TO stays set.
        if (wdt_clr_s) begin
            to_n_nxt_s = 1'b1;
        end else if (wdt_fire_s) begin
            to_n_nxt_s = 1'b0;
        end else begin
            to_n_nxt_s = to_n_r;
        end

        if (sleep) begin
            pd_n_nxt_s = 1'b0;
        end else if (clrwdt) begin
            pd_n_nxt_s = 1'b1;
        end else begin
            pd_n_nxt_s = pd_n_r;
        end
    end

    // T0CKI synchroniser, edge register and post-reset arming counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            edge_r  <= 1'b0;
            arm_r   <= 2'd0;
        end else begin
            sync1_r <= t0cki;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
            arm_r   <= arm_nxt_s;
        end
    end

    // OPTION copy, prescaler, WDT base, write inhibit and sleep flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opt_r    <= 4'd0;
            psc_r    <= 8'd0;
            base_r   <= {WDT_BASE_W{1'b0}};
            inh_r    <= 2'd0;
            asleep_r <= 1'b0;
        end else begin
            opt_r    <= option[3:0];
            psc_r    <= psc_nxt_s;
            base_r   <= base_nxt_s;
            inh_r    <= inh_nxt_s;
            asleep_r <= asleep_r | sleep;
        end
    end

    // Registered strobes and STATUS bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0_inc_r <= 1'b0;
            wdtmr_r    <= 1'b0;
            to_n_r     <= 1'b1;
            pd_n_r     <= 1'b1;
        end else begin
            tmr0_inc_r <= t0_fire_s;
            wdtmr_r    <= wdt_fire_s;
            to_n_r     <= to_n_nxt_s;
            pd_n_r     <= pd_n_nxt_s;
        end
    end

    assign tmr0_inc = tmr0_inc_r;
    assign wdtmr    = wdtmr_r;
    assign to_n     = to_n_r;
    assign pd_n     = pd_n_r;

endmodule
